// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, FSM state encodings and the parity helper.
package uart_pkg;

    localparam int FRAME_BITS = 11;
    localparam int DATA_BITS  = 8;
    // Wide enough to count every bit position of a frame.
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP,
        TX_GUARD
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/baud_gen.sv
// Free-running bit-period counter producing a one-cycle baud tick every DIV clocks.
module baud_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    output logic baud_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] count;

    // The tick is registered one count early so it is high exactly while count == DIV-1.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count     <= '0;
            baud_tick <= 1'b0;
        end else begin
            if (count == CW'(DIV - 1)) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
            baud_tick <= (count == CW'(DIV - 2));
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizes the serial line and samples one bit per baud tick.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  baud_tick,
    input  logic                  rx_serial,
    output logic                  data_valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  parity_err,
    output logic                  frame_err
);

    rx_state_t             state;
    logic                  sync_1;
    logic                  sync_2;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  parity_bit;
    logic [CNT_W-1:0]      bit_cnt;

    // Reset to the idle line level so a reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= rx_serial;
            sync_2 <= sync_1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= RX_IDLE;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            bit_cnt    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (baud_tick) begin
                case (state)
                    RX_IDLE: begin
                        if (!sync_2) begin
                            bit_cnt <= '0;
                            state   <= RX_DATA;
                        end
                    end
                    RX_DATA: begin
                        shift_reg <= {sync_2, shift_reg[DATA_WIDTH-1:1]};
                        if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                            state <= RX_PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    RX_PARITY: begin
                        parity_bit <= sync_2;
                        state      <= RX_STOP;
                    end
                    RX_STOP: begin
                        if (sync_2) begin
                            data_out   <= shift_reg;
                            data_valid <= 1'b1;
                            parity_err <= even_parity(shift_reg) ^ parity_bit;
                        end else begin
                            frame_err  <= 1'b1;
                        end
                        state <= RX_IDLE;
                    end
                    default: begin
                        state <= RX_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, LSB-first data, even parity, stop and one guard bit, advanced on baud ticks.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  baud_tick,
    input  logic                  data_ready,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  tx_serial,
    output logic                  tx_busy
);

    tx_state_t             state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  parity_bit;
    logic [CNT_W-1:0]      bit_cnt;

    // The guard period doubles as an idle tick, so a waiting request starts the next frame there.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= TX_IDLE;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            bit_cnt    <= '0;
            tx_serial  <= 1'b1;
            tx_busy    <= 1'b0;
        end else if (baud_tick) begin
            case (state)
                TX_IDLE, TX_GUARD: begin
                    if (data_ready) begin
                        shift_reg  <= data_in;
                        parity_bit <= even_parity(data_in);
                        tx_serial  <= 1'b0;
                        tx_busy    <= 1'b1;
                        state      <= TX_START;
                    end else begin
                        tx_serial  <= 1'b1;
                        tx_busy    <= 1'b0;
                        state      <= TX_IDLE;
                    end
                end
                TX_START: begin
                    tx_serial <= shift_reg[0];
                    shift_reg <= shift_reg >> 1;
                    bit_cnt   <= CNT_W'(1);
                    state     <= TX_DATA;
                end
                TX_DATA: begin
                    if (bit_cnt == CNT_W'(DATA_WIDTH)) begin
                        tx_serial <= parity_bit;
                        state     <= TX_PARITY;
                    end else begin
                        tx_serial <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        bit_cnt   <= bit_cnt + 1'b1;
                    end
                end
                TX_PARITY: begin
                    tx_serial <= 1'b1;
                    state     <= TX_STOP;
                end
                TX_STOP: begin
                    tx_serial <= 1'b1;
                    state     <= TX_GUARD;
                end
                default: begin
                    tx_serial <= 1'b1;
                    tx_busy   <= 1'b0;
                    state     <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART: one baud generator shared by an independent transmitter and receiver.
module uart_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 10_000,
    parameter int BAUD_RATE  = 1000,
    parameter int DATA_WIDTH = DATA_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_ready,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  tx_serial,
    output logic                  tx_busy,
    input  logic                  rx_serial,
    output logic                  data_valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  parity_err,
    output logic                  frame_err
);

    localparam int DIV = CLK_FREQ / BAUD_RATE;

    logic baud_tick;

    baud_gen #(
        .DIV (DIV)
    ) u_baud_gen (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick)
    );

    uart_tx #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_uart_tx (
        .clk        (clk),
        .rst        (rst),
        .baud_tick  (baud_tick),
        .data_ready (data_ready),
        .data_in    (data_in),
        .tx_serial  (tx_serial),
        .tx_busy    (tx_busy)
    );

    uart_rx #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_uart_rx (
        .clk        (clk),
        .rst        (rst),
        .baud_tick  (baud_tick),
        .rx_serial  (rx_serial),
        .data_valid (data_valid),
        .data_out   (data_out),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

endmodule

// File: tb/tb_uart_core.sv
// Loopback bench for uart_core: table vectors, random bytes against a frame model, and error/reset corners.
module tb_uart_core;

    localparam int CLK_FREQ   = 10_000;
    localparam int BAUD_RATE  = 1000;
    localparam int DATA_WIDTH = 8;
    localparam int DIV        = CLK_FREQ / BAUD_RATE;

    typedef struct {
        logic [7:0]  data;
        logic [11:0] frame;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       data_ready;
    logic [7:0] data_in;
    logic       tx_serial;
    logic       tx_busy;
    logic       rx_serial;
    logic       data_valid;
    logic [7:0] data_out;
    logic       parity_err;
    logic       frame_err;

    logic inject  = 1'b0;
    logic inj_bit = 1'b1;

    int checks      = 0;
    int errors      = 0;
    int cyc         = 0;
    int valid_count = 0;
    int ferr_count  = 0;

    vec_t vecs [5];

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (data_valid === 1'b1) valid_count++;
        if (frame_err === 1'b1) ferr_count++;
    end

    assign rx_serial = inject ? inj_bit : tx_serial;

    uart_core #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .DATA_WIDTH (DATA_WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_ready (data_ready),
        .data_in    (data_in),
        .tx_serial  (tx_serial),
        .tx_busy    (tx_busy),
        .rx_serial  (rx_serial),
        .data_valid (data_valid),
        .data_out   (data_out),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    // Reference frame: bit k is the line level during bit period k (start, data LSB first, parity, stop, guard).
    function automatic logic [11:0] model_frame(input logic [7:0] b);
        logic [11:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            f[k+1] = b[k];
            ones += int'(b[k]);
        end
        f[9]  = (ones % 2 == 1);
        f[10] = 1'b1;
        f[11] = 1'b1;
        return f;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    // Returns 1 time unit after the next rising edge on which the baud tick was high.
    task automatic wait_tick_edge();
        for (int n = 0; n < 4 * DIV; n++) begin
            @(negedge clk);
            if (dut.baud_tick === 1'b1) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        checkOutput("tick_timeout", 32'd0, 32'd1);
    endtask

    // Called just after the accept tick T0; follows the line through T11 and checks the loopback result.
    task automatic watch_frame(input logic [7:0] b, input logic [11:0] frame);
        int t0;
        t0 = cyc;
        checkOutput($sformatf("tx_bit0_%02h", b), tx_serial, frame[0]);
        checkOutput($sformatf("tx_busy0_%02h", b), tx_busy, 1'b1);
        for (int k = 1; k < 12; k++) begin
            wait_tick_edge();
            checkOutput($sformatf("tx_bit%0d_%02h", k, b), tx_serial, frame[k]);
            checkOutput($sformatf("tx_busy%0d_%02h", k, b), tx_busy, 1'b1);
        end
        checkOutput($sformatf("rx_valid_%02h", b), data_valid, 1'b1);
        checkOutput($sformatf("rx_data_%02h", b), data_out, b);
        checkOutput($sformatf("rx_perr_%02h", b), parity_err, 1'b0);
        checkOutput($sformatf("rx_latency_%02h", b), cyc - t0, 11 * DIV);
    endtask

    task automatic finish_frame(input logic [7:0] b);
        wait_tick_edge();
        checkOutput($sformatf("tx_busy12_%02h", b), tx_busy, 1'b0);
        checkOutput($sformatf("tx_idle12_%02h", b), tx_serial, 1'b1);
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic [11:0] frame);
        data_in    = b;
        data_ready = 1'b1;
        wait_tick_edge();
        data_ready = 1'b0;
        watch_frame(b, frame);
        finish_frame(b);
    endtask

    // Drives a raw frame onto rx_serial, one bit per tick; returns just after the tick that samples the stop bit.
    task automatic inject_frame(input logic [11:0] bits);
        for (int k = 0; k < 12; k++) begin
            wait_tick_edge();
            inj_bit = bits[k];
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int v_before;
        logic [7:0] rb;

        rst        = 1'b0;
        data_ready = 1'b0;
        data_in    = 8'h00;

        vecs[0] = '{8'h43, 12'hE86};
        vecs[1] = '{8'h72, 12'hCE4};
        vecs[2] = '{8'hA5, 12'hD4A};
        vecs[3] = '{8'hE7, 12'hDCE};
        vecs[4] = '{8'hF4, 12'hFE8};

        $display("[TB] reset");
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_tx_serial", tx_serial, 1'b1);
        checkOutput("rst_tx_busy", tx_busy, 1'b0);
        checkOutput("rst_data_valid", data_valid, 1'b0);
        checkOutput("rst_data_out", data_out, 8'h00);
        checkOutput("rst_parity_err", parity_err, 1'b0);
        checkOutput("rst_frame_err", frame_err, 1'b0);
        rst = 1'b1;
        n = 1;
        while (dut.baud_tick !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("first_tick_cycle", n, 10);

        $display("[TB] table vectors");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].data, vecs[i].frame);
        end

        $display("[TB] random bytes");
        for (int i = 0; i < 6; i++) begin
            rb = 8'($urandom_range(0, 255));
            applyStimulus(rb, model_frame(rb));
        end

        $display("[TB] back-to-back");
        data_in    = 8'hA5;
        data_ready = 1'b1;
        wait_tick_edge();
        data_in = 8'hE7;
        watch_frame(8'hA5, 12'hD4A);
        wait_tick_edge();
        data_ready = 1'b0;
        watch_frame(8'hE7, 12'hDCE);
        finish_frame(8'hE7);

        $display("[TB] parity and framing errors");
        inj_bit = 1'b1;
        inject  = 1'b1;
        inject_frame(12'hF4A);
        checkOutput("perr_valid", data_valid, 1'b1);
        checkOutput("perr_flag", parity_err, 1'b1);
        checkOutput("perr_data", data_out, 8'hA5);
        inject_frame(model_frame(8'h3C) & ~12'h400);
        checkOutput("ferr_flag", frame_err, 1'b1);
        checkOutput("ferr_valid", data_valid, 1'b0);
        checkOutput("ferr_data_hold", data_out, 8'hA5);
        inject = 1'b0;

        $display("[TB] mid-frame reset");
        data_in    = 8'h0F;
        data_ready = 1'b1;
        wait_tick_edge();
        data_ready = 1'b0;
        repeat (5) wait_tick_edge();
        checkOutput("mid_pre_reset_line", tx_serial, 1'b0);
        v_before = valid_count;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("mid_reset_tx_serial", tx_serial, 1'b1);
        checkOutput("mid_reset_tx_busy", tx_busy, 1'b0);
        checkOutput("mid_reset_data_out", data_out, 8'h00);
        rst = 1'b1;
        repeat (14) wait_tick_edge();
        checkOutput("mid_reset_no_valid", valid_count, v_before);
        checkOutput("mid_reset_line_idle", tx_serial, 1'b1);

        checkOutput("total_valid_pulses", valid_count, 14);
        checkOutput("total_frame_err_pulses", ferr_count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
